// File: rtl/udp_pkg.sv
// Shared constants, FSM state type and payload-length clamp for the UDP
// test-packet generator.
package udp_pkg;

  localparam int UDP_HDR_LEN         = 8;
  localparam int UDP_MIN_GEN_PAYLOAD = 4;
  localparam int UDP_MAX_PAYLOAD     = 1472;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    GAP
  } gen_state_t;

  // Keeps room for the 4-byte sequence number and fits one Ethernet MTU.
  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < 16'(UDP_MIN_GEN_PAYLOAD)) begin
      return 16'(UDP_MIN_GEN_PAYLOAD);
    end else if (len > 16'(UDP_MAX_PAYLOAD)) begin
      return 16'(UDP_MAX_PAYLOAD);
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/udp_packet_generator_if.sv
// Header request channel into the UDP stack and the 8-bit AXI-Stream
// payload channel.
interface udp_header_interface;
  logic        valid;
  logic        ready;
  logic [31:0] source_ip;
  logic [31:0] dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] udp_length;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [7:0]  ttl;
  logic [15:0] checksum;

  modport master (
    output valid, source_ip, dest_ip, source_port, dest_port,
           udp_length, dscp, ecn, ttl, checksum,
    input  ready
  );
  modport slave (
    input  valid, source_ip, dest_ip, source_port, dest_port,
           udp_length, dscp, ecn, ttl, checksum,
    output ready
  );
endinterface

interface axis_interface;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_packet_generator.sv
// Periodic UDP test-packet source: header request, sequence-numbered ramp
// payload, then a programmable idle gap.
module udp_packet_generator
  import udp_pkg::*;
#(
  parameter logic [31:0] SRC_IP     = 32'hC0A8_0180,
  parameter logic [31:0] DST_IP     = 32'hC0A8_0164,
  parameter logic [15:0] SRC_PORT   = 16'd5000,
  parameter logic [15:0] DST_PORT   = 16'd5000,
  parameter logic [31:0] GAP_CYCLES = 32'd125000
) (
  input  logic                       udp_sys_clk,
  input  logic                       system_reset_n,
  input  logic                       enable,
  input  logic [15:0]                payload_len,
  udp_header_interface.master        udp_hdr,
  axis_interface.master              axis_payload_out,
  output logic [31:0]                packets_sent,
  output logic                       busy
);

  gen_state_t  state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] idx_reg, idx_next;
  logic [31:0] seq_reg, seq_next;
  logic [31:0] sent_reg, sent_next;
  logic [31:0] gap_reg, gap_next;
  // Holds off the first packet until one clock after reset release.
  logic        start_ok_reg;

  logic [7:0]  seq_bytes [4];
  logic        in_hdr, in_payload, gap_done;

  for (genvar gi = 0; gi < 4; gi++) begin : g_seq_bytes
    assign seq_bytes[gi] = seq_reg[31-8*gi -: 8];
  end

  always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      seq_reg      <= '0;
      sent_reg     <= '0;
      gap_reg      <= '0;
      start_ok_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      seq_reg      <= seq_next;
      sent_reg     <= sent_next;
      gap_reg      <= gap_next;
      start_ok_reg <= 1'b1;
    end
  end

  // Widened compare so GAP_CYCLES near 2^32 cannot wrap the counter test.
  assign gap_done = ({1'b0, gap_reg} + 33'd1) >= {1'b0, GAP_CYCLES};

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    seq_next   = seq_reg;
    sent_next  = sent_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (enable && start_ok_reg) begin
          len_next   = clamp_len(payload_len);
          state_next = HDR;
        end
      end
      HDR: begin
        if (udp_hdr.ready) begin
          idx_next   = '0;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (axis_payload_out.tready) begin
          if (idx_reg == len_reg - 16'd1) begin
            idx_next   = '0;
            seq_next   = seq_reg + 32'd1;
            sent_next  = sent_reg + 32'd1;
            gap_next   = '0;
            state_next = GAP;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_hdr     = (state_reg == HDR);
  assign in_payload = (state_reg == PAYLOAD);

  assign udp_hdr.valid       = in_hdr;
  assign udp_hdr.source_ip   = in_hdr ? SRC_IP : 32'd0;
  assign udp_hdr.dest_ip     = in_hdr ? DST_IP : 32'd0;
  assign udp_hdr.source_port = in_hdr ? SRC_PORT : 16'd0;
  assign udp_hdr.dest_port   = in_hdr ? DST_PORT : 16'd0;
  assign udp_hdr.udp_length  = in_hdr ? (len_reg + 16'(UDP_HDR_LEN)) : 16'd0;
  assign udp_hdr.dscp        = 6'd0;
  assign udp_hdr.ecn         = 2'd0;
  assign udp_hdr.ttl         = in_hdr ? 8'd64 : 8'd0;
  assign udp_hdr.checksum    = 16'd0;

  assign axis_payload_out.tvalid = in_payload;
  assign axis_payload_out.tlast  = in_payload && (idx_reg == len_reg - 16'd1);
  assign axis_payload_out.tdata  = !in_payload      ? 8'd0 :
                                   (idx_reg < 16'd4) ? seq_bytes[idx_reg[1:0]] :
                                                       idx_reg[7:0];

  assign packets_sent = sent_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_udp_packet_generator.sv
// Self-checking bench for udp_packet_generator: table of lengths, header
// stall, random lengths/backpressure, enable drop and mid-packet reset.
module tb_udp_packet_generator;

  localparam logic [31:0] GAP = 32'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] payload_len = 16'd0;
  logic [31:0] packets_sent;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_seq = 32'd0;
  logic [31:0] exp_sent = 32'd0;

  udp_header_interface hdr_if ();
  axis_interface       axis_if ();

  udp_packet_generator #(.GAP_CYCLES(GAP)) dut (
    .udp_sys_clk      (clk),
    .system_reset_n   (rst_n),
    .enable           (enable),
    .payload_len      (payload_len),
    .udp_hdr          (hdr_if.master),
    .axis_payload_out (axis_if.master),
    .packets_sent     (packets_sent),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_len(input int p);
    if (p < 4) return 4;
    if (p > 1472) return 1472;
    return p;
  endfunction

  // One complete packet: header, payload against an expected-byte queue, gap.
  task automatic run_packet(input int plen, input int exp_udp_len, input int rdy_pct,
                            input bit hdr_stall, input bit drop_en);
    logic [7:0] exp_q[$];
    int         n, cyc, n_hs, stalls, g;
    logic       hs;
    n = exp_udp_len - 8;
    for (int i = 0; i < n; i++) begin
      if (i < 4) exp_q.push_back(8'(exp_seq >> (8 * (3 - i))));
      else       exp_q.push_back(8'(i % 256));
    end
    payload_len    = 16'(plen);
    enable         = 1'b1;
    hdr_if.ready   = !hdr_stall;
    axis_if.tready = 1'b0;
    cyc = 0;
    while (!hdr_if.valid && cyc < 200) begin
      check("tvalid_before_hdr", {31'd0, axis_if.tvalid}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    check("hdr_valid", {31'd0, hdr_if.valid}, 32'd1);
    payload_len = 16'($urandom);
    check("udp_length", {16'd0, hdr_if.udp_length}, 32'(exp_udp_len));
    check("source_ip", hdr_if.source_ip, 32'hC0A80180);
    check("dest_ip", hdr_if.dest_ip, 32'hC0A80164);
    check("ports", {hdr_if.source_port, hdr_if.dest_port}, {16'd5000, 16'd5000});
    check("ttl_dscp_ecn", {16'd0, hdr_if.ttl, hdr_if.dscp, hdr_if.ecn}, {16'd0, 8'd64, 8'd0});
    check("checksum", {16'd0, hdr_if.checksum}, 32'd0);
    if (hdr_stall) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check("stall_hdr_valid", {31'd0, hdr_if.valid}, 32'd1);
        check("stall_udp_length", {16'd0, hdr_if.udp_length}, 32'(exp_udp_len));
        check("stall_tvalid", {31'd0, axis_if.tvalid}, 32'd0);
      end
      hdr_if.ready = 1'b1;
    end
    @(negedge clk);
    check("hdr_valid_dropped", {31'd0, hdr_if.valid}, 32'd0);
    cyc = 0; n_hs = 0; stalls = 0;
    while (exp_q.size() > 0 && cyc < n * 30 + 100) begin
      axis_if.tready = ($urandom_range(0, 99) < rdy_pct);
      check("tvalid", {31'd0, axis_if.tvalid}, 32'd1);
      check("tdata", {24'd0, axis_if.tdata}, {24'd0, exp_q[0]});
      check("tlast", {31'd0, axis_if.tlast}, {31'd0, exp_q.size() == 1});
      if (drop_en && exp_q.size() == n / 2) enable = 1'b0;
      hs = axis_if.tready && axis_if.tvalid;
      if (!axis_if.tready) stalls++;
      @(negedge clk);
      cyc++;
      if (hs) begin
        void'(exp_q.pop_front());
        n_hs++;
      end
    end
    axis_if.tready = 1'b0;
    check("payload_handshakes", n_hs, n);
    exp_seq++;
    exp_sent++;
    check("post_tvalid_tlast", {30'd0, axis_if.tvalid, axis_if.tlast}, 32'd0);
    g = 0;
    while (busy && g < 1000) begin
      if (hdr_if.valid || axis_if.tvalid) g = 1000;
      g++;
      @(negedge clk);
    end
    check("gap_cycles", g, GAP);
    check("packets_sent", packets_sent, exp_sent);
    $display("pkt seq=%0d udp_length=%0d handshakes=%0d stalls=%0d gap=%0d",
             exp_seq - 1, exp_udp_len, n_hs, stalls, g);
  endtask

  typedef struct {
    int plen;
    int exp_udp_len;
    int rdy_pct;
  } vec_t;

  vec_t vecs[8];
  int   seen;
  int   p;

  initial begin
    vecs[0] = '{16,   24,   100};
    vecs[1] = '{2,    12,   50};
    vecs[2] = '{2000, 1480, 50};
    vecs[3] = '{0,    12,   50};
    vecs[4] = '{4,    12,   100};
    vecs[5] = '{1472, 1480, 50};
    vecs[6] = '{1473, 1480, 100};
    vecs[7] = '{100,  108,  50};

    hdr_if.ready   = 1'b1;
    axis_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hdr_valid", {31'd0, hdr_if.valid}, 32'd0);
    check("rst_tvalid_tlast", {30'd0, axis_if.tvalid, axis_if.tlast}, 32'd0);
    check("rst_tdata", {24'd0, axis_if.tdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_packets_sent", packets_sent, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_packet(vecs[v].plen, vecs[v].exp_udp_len, vecs[v].rdy_pct, 1'b0, 1'b0);
    end

    run_packet(40, 48, 70, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 300));
      run_packet(p, model_len(p) + 8, int'($urandom_range(20, 100)), 1'b0, 1'b0);
    end

    run_packet(30, 38, 70, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (hdr_if.valid || busy) seen++;
      @(negedge clk);
    end
    check("no_hdr_after_disable", seen, 0);

    // Abort a packet at payload byte 7 with an asynchronous reset.
    enable         = 1'b1;
    payload_len    = 16'd20;
    axis_if.tready = 1'b1;
    seen = 0;
    while (!axis_if.tvalid && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    repeat (7) @(negedge clk);
    check("abort_byte7", {24'd0, axis_if.tdata}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("abort_hdr_valid", {31'd0, hdr_if.valid}, 32'd0);
    check("abort_axis", {22'd0, axis_if.tdata, axis_if.tvalid, axis_if.tlast}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_packets_sent", packets_sent, 32'd0);
    axis_if.tready = 1'b0;
    exp_seq  = 32'd0;
    exp_sent = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("start_not_first_edge", {30'd0, busy, hdr_if.valid}, 32'd0);
    @(negedge clk);
    check("start_second_edge", {31'd0, hdr_if.valid}, 32'd1);
    run_packet(20, 28, 60, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
